memctl_resp: RTL and testbench

Memory responder for the exec unit's data port. Accepts one request per transaction (20-bit byte address, 16-bit write data, active-low write enable, byte/word select) and executes it as one or two cycles on the 16-bit Wishbone-style external bus. Steers bytes onto the correct lanes, splits unaligned word accesses into two bus cycles, and returns assembled read data on `memout` with a one-cycle `ready` pulse. Sits between the exec datapath and the memory/IO bus.

---
 rtl/memctl_pkg.sv | 26 ++
 rtl/memctl_lane.sv | 50 +++++
 rtl/memctl_resp.sv | 237 +++++++++++++++++++++++
 tb/tb_memctl_resp.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memctl_pkg.sv
// -----------------------------------------------------------------------------
// memctl_pkg
// Shared definitions for the exec data-port memory responder:
//   - state_e      : responder FSM states (2-bit encoding)
//   - SEL_LO/HI/W  : Wishbone byte-lane enables ([0] = even byte, [1] = odd byte)
//   - place_byte() : puts one byte on the lane chosen by the address LSB
// -----------------------------------------------------------------------------
package memctl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC1 = 2'd1,
      ST_ACC2 = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   localparam logic [1:0] SEL_LO = 2'b01;
   localparam logic [1:0] SEL_HI = 2'b10;
   localparam logic [1:0] SEL_W  = 2'b11;

   // Odd byte addresses live on the upper lane, even ones on the lower lane.
   function automatic logic [15:0] place_byte(input logic odd, input logic [7:0] b);
      return odd ? {b, 8'h00} : {8'h00, b};
   endfunction

endpackage

// File: rtl/memctl_lane.sv
// -----------------------------------------------------------------------------
// memctl_lane
// Combinational byte-lane steering for memctl_resp.
// Ports:
//   odd_i      : byte address bit 0 of the access
//   byteop_i   : 1 = byte access, 0 = word access
//   second_i   : 1 while the second half of a split word is on the bus
//   wd_i       : write data as presented by the exec unit
//   dat_i      : read data from the bus
//   acc1_sel_o : lane enables for the first (or only) bus cycle
//   acc1_dat_o : lane-steered write data for the first bus cycle
//   acc2_sel_o : lane enables for the second half of a split word
//   acc2_dat_o : lane-steered write data for the second half of a split word
//   rd_byte_o  : read byte picked from the lane the current cycle addresses
// -----------------------------------------------------------------------------
module memctl_lane
   import memctl_pkg::*;
(
   input  logic        odd_i,
   input  logic        byteop_i,
   input  logic        second_i,
   input  logic [15:0] wd_i,
   input  logic [15:0] dat_i,
   output logic [1:0]  acc1_sel_o,
   output logic [15:0] acc1_dat_o,
   output logic [1:0]  acc2_sel_o,
   output logic [15:0] acc2_dat_o,
   output logic [7:0]  rd_byte_o
);

   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      acc1_sel_o = SEL_W;
      acc1_dat_o = wd_i;
      // A byte access, or the first half of an unaligned word, moves only the
      // low byte of the write data, onto the lane named by the address LSB.
      if (byteop_i || odd_i) begin
         acc1_sel_o = odd_i ? SEL_HI : SEL_LO;
         acc1_dat_o = place_byte(odd_i, wd_i[7:0]);
      end

      // The second half of an unaligned word is always the even byte of the
      // next word and carries the high byte of the write data.
      acc2_sel_o = SEL_LO;
      acc2_dat_o = place_byte(1'b0, wd_i[15:8]);

      rd_byte_o = (odd_i && !second_i) ? dat_i[15:8] : dat_i[7:0];
   end

endmodule

// File: rtl/memctl_resp.sv
// -----------------------------------------------------------------------------
// memctl_resp
// Memory responder for the exec unit's data port. Runs each request as one
// bus cycle (byte or aligned word) or two bus cycles (unaligned word) on a
// 16-bit Wishbone-style bus and returns assembled read data with a one-cycle
// ready pulse.
//
// Optional feature: define MEMCTL_TIMEOUT_EN to add a bus watchdog that ends a
// stalled access after TIMEOUT_CYCLES cycles without ack (read data FFFF) and
// raises the sticky err output.
//
// Ports:
//   clk, boot          : clock, synchronous active-high reset
//   req                : request strobe (sampled only when idle)
//   addr, wr_data      : byte address, write data
//   we, byteop         : active-low write enable, byte/word select
//   memout, ready      : read data (held), completion pulse
//   err                : sticky timeout flag (MEMCTL_TIMEOUT_EN only)
//   wb_*               : external bus master interface
// -----------------------------------------------------------------------------
module memctl_resp
   import memctl_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        boot,
   input  logic        req,
   input  logic [19:0] addr,
   input  logic [15:0] wr_data,
   input  logic        we,
   input  logic        byteop,
   output logic [15:0] memout,
   output logic        ready,
`ifdef MEMCTL_TIMEOUT_EN
   output logic        err,
`endif
   output logic [18:0] wb_adr_o,
   output logic [15:0] wb_dat_o,
   input  logic [15:0] wb_dat_i,
   output logic [1:0]  wb_sel_o,
   output logic        wb_we_o,
   output logic        wb_cyc_o,
   output logic        wb_stb_o,
   input  logic        wb_ack_i
);

   state_e      state_q;
   logic [19:0] addr_q;
   logic [15:0] wd_q;
   logic        we_n_q;
   logic        byte_q;
   logic        split_q;
   logic [7:0]  lo_q;       // low byte captured from the first half of a split read
   logic [15:0] memout_q;
   logic        ready_q;
   logic        stb_q;
   logic [18:0] adr_q;
   logic [15:0] dat_q;
   logic [1:0]  sel_q;
   logic        we_o_q;

   logic        is_idle;
   logic        busy;
   logic        ack_seen;
   logic        ack_fin;
   logic        timeout_hit;
   logic        finish;
   logic [15:0] fin_data;

   logic        lane_odd;
   logic        lane_byteop;
   logic [15:0] lane_wd;
   logic [1:0]  lane_acc1_sel;
   logic [15:0] lane_acc1_dat;
   logic [1:0]  lane_acc2_sel;
   logic [15:0] lane_acc2_dat;
   logic [7:0]  lane_rd_byte;

   assign is_idle  = (state_q == ST_IDLE);
   assign busy     = (state_q == ST_ACC1) || (state_q == ST_ACC2);
   // Strobe is only ever high in ACC1/ACC2; the gap cycle of a split access
   // has strobe low, so an ack there is ignored as well.
   assign ack_seen = stb_q && wb_ack_i;
   assign ack_fin  = ack_seen && ((state_q == ST_ACC2) || !split_q);
   assign finish   = ack_fin || timeout_hit;

   // While idle the first bus cycle is set up straight from the request
   // inputs; afterwards the lane logic works from the latched request.
   assign lane_odd    = is_idle ? addr[0] : addr_q[0];
   assign lane_byteop = is_idle ? byteop  : byte_q;
   assign lane_wd     = is_idle ? wr_data : wd_q;

   memctl_lane u_lane (
      .odd_i      (lane_odd),
      .byteop_i   (lane_byteop),
      .second_i   (state_q == ST_ACC2),
      .wd_i       (lane_wd),
      .dat_i      (wb_dat_i),
      .acc1_sel_o (lane_acc1_sel),
      .acc1_dat_o (lane_acc1_dat),
      .acc2_sel_o (lane_acc2_sel),
      .acc2_dat_o (lane_acc2_dat),
      .rd_byte_o  (lane_rd_byte)
   );

   // Read data returned on completion; a watchdog expiry returns all ones.
   always_comb begin
      fin_data = 16'hFFFF;
      if (ack_fin) begin
         if (state_q == ST_ACC2) begin
            fin_data = {lane_rd_byte, lo_q};
         end else if (byte_q) begin
            fin_data = {8'h00, lane_rd_byte};
         end else begin
            fin_data = wb_dat_i;
         end
      end
   end

`ifdef MEMCTL_TIMEOUT_EN
   localparam logic [7:0] TO_LIM = TIMEOUT_CYCLES[7:0];

   logic [7:0] cnt_q;
   logic       err_q;

   assign timeout_hit = busy && !ack_seen && (cnt_q == TO_LIM);

   always_ff @(posedge clk) begin
      if (boot) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         if (busy && !ack_seen) begin
            cnt_q <= cnt_q + 8'd1;
         end else begin
            cnt_q <= '0;
         end
         if (timeout_hit) begin
            err_q <= 1'b1;
         end
      end
   end

   assign err = err_q;
`else
   assign timeout_hit = 1'b0;

   // The watchdog limit only matters when the watchdog is built in.
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

   always_ff @(posedge clk) begin
      // NOTE: state is updated with non-blocking assignments so every register
      // sees the pre-edge values of the others, whatever the statement order.
      if (boot) begin
         state_q  <= ST_IDLE;
         addr_q   <= '0;
         wd_q     <= '0;
         we_n_q   <= 1'b1;
         byte_q   <= 1'b0;
         split_q  <= 1'b0;
         lo_q     <= '0;
         memout_q <= '0;
         ready_q  <= 1'b0;
         stb_q    <= 1'b0;
         adr_q    <= '0;
         dat_q    <= '0;
         sel_q    <= '0;
         we_o_q   <= 1'b0;
      end else begin
         ready_q <= 1'b0;
         if (finish) begin
            state_q <= ST_DONE;
            ready_q <= 1'b1;
            stb_q   <= 1'b0;
            sel_q   <= '0;
            we_o_q  <= 1'b0;
            if (we_n_q) begin
               memout_q <= fin_data;
            end
         end else begin
            unique case (state_q)
               ST_IDLE: begin
                  if (req) begin
                     state_q <= ST_ACC1;
                     addr_q  <= addr;
                     wd_q    <= wr_data;
                     we_n_q  <= we;
                     byte_q  <= byteop;
                     split_q <= !byteop && addr[0];
                     stb_q   <= 1'b1;
                     adr_q   <= addr[19:1];
                     sel_q   <= lane_acc1_sel;
                     dat_q   <= lane_acc1_dat;
                     we_o_q  <= !we;
                  end
               end
               ST_ACC1: begin
                  // Only a split access reaches here on ack (ack_fin covers the rest).
                  if (ack_seen) begin
                     state_q <= ST_ACC2;
                     lo_q    <= lane_rd_byte;
                     stb_q   <= 1'b0;
                     adr_q   <= addr_q[19:1] + 19'd1;
                     sel_q   <= lane_acc2_sel;
                     dat_q   <= lane_acc2_dat;
                  end
               end
               ST_ACC2: begin
                  // First ACC2 cycle is the mandatory strobe-low gap.
                  if (!stb_q) begin
                     stb_q <= 1'b1;
                  end
               end
               ST_DONE: begin
                  state_q <= ST_IDLE;
               end
               default: begin
                  state_q <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign memout   = memout_q;
   assign ready    = ready_q;
   assign wb_adr_o = adr_q;
   assign wb_dat_o = dat_q;
   assign wb_sel_o = sel_q;
   assign wb_we_o  = we_o_q;
   assign wb_cyc_o = stb_q;
   assign wb_stb_o = stb_q;

endmodule

// File: tb/tb_memctl_resp.sv
// -----------------------------------------------------------------------------
// tb_memctl_resp
// Self-checking bench for memctl_resp. The reference is a little-endian byte
// memory: each request is reduced to the byte addresses it touches, from which
// the expected bus cycles, read data and latency follow. A separate slave
// memory is updated only through the DUT's bus writes and serves its reads.
// Define MEMCTL_TIMEOUT_EN for both DUT and bench to cover the watchdog.
// -----------------------------------------------------------------------------
module tb_memctl_resp;

   localparam int unsigned TO_LIM = 4;

   logic        clk = 1'b0;
   logic        boot;
   logic        req;
   logic [19:0] addr;
   logic [15:0] wr_data;
   logic        we;
   logic        byteop;
   logic [15:0] memout;
   logic        ready;
`ifdef MEMCTL_TIMEOUT_EN
   logic        err;
   logic        err_exp = 1'b0;
`endif
   logic [18:0] wb_adr_o;
   logic [15:0] wb_dat_o;
   logic [15:0] wb_dat_i;
   logic [1:0]  wb_sel_o;
   logic        wb_we_o;
   logic        wb_cyc_o;
   logic        wb_stb_o;
   logic        wb_ack_i;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [15:0] memout_exp = 16'h0000;
   logic [7:0]  mmem [int];   // reference byte memory (specification view)
   logic [7:0]  smem [int];   // slave memory, written only by DUT bus cycles

   always #5 clk = ~clk;

   memctl_resp #(.TIMEOUT_CYCLES(TO_LIM)) dut (
      .clk      (clk),
      .boot     (boot),
      .req      (req),
      .addr     (addr),
      .wr_data  (wr_data),
      .we       (we),
      .byteop   (byteop),
      .memout   (memout),
      .ready    (ready),
`ifdef MEMCTL_TIMEOUT_EN
      .err      (err),
`endif
      .wb_adr_o (wb_adr_o),
      .wb_dat_o (wb_dat_o),
      .wb_dat_i (wb_dat_i),
      .wb_sel_o (wb_sel_o),
      .wb_we_o  (wb_we_o),
      .wb_cyc_o (wb_cyc_o),
      .wb_stb_o (wb_stb_o),
      .wb_ack_i (wb_ack_i)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] init_byte(input logic [19:0] a);
      return a[7:0] ^ a[15:8] ^ {a[19:16], 4'h9};
   endfunction

   function automatic logic [7:0] m_get(input logic [19:0] a);
      return mmem.exists(int'(a)) ? mmem[int'(a)] : init_byte(a);
   endfunction

   function automatic logic [7:0] s_get(input logic [19:0] a);
      return smem.exists(int'(a)) ? smem[int'(a)] : init_byte(a);
   endfunction

   task automatic preload(input logic [19:0] a, input logic [7:0] b);
      mmem[int'(a)] = b;
      smem[int'(a)] = b;
   endtask

   // One request with w1/w2 wait states on the first/second bus cycle.
   // hold keeps req high after acceptance (it must be ignored while busy).
   task automatic run_txn(input logic [19:0] a, input logic [15:0] d, input logic w_n,
                          input logic b, input int w1, input int w2, input bit hold);
      logic [19:0] a1;
      logic [18:0] e_adr [2];
      logic [1:0]  e_sel [2];
      logic [15:0] e_dat [2];
      logic [19:0] ba [2];
      logic [7:0]  bd [2];
      int          bp [2];
      int          waits [2];
      bit          split;
      bit          done;
      int          nph, nb, exp_lat, exp_stbs, ph, inph, stbs, k;

      a1    = a + 20'd1;
      split = !b && a[0];
      nph   = split ? 2 : 1;
      nb    = b ? 1 : 2;
      ba[0] = a;  bd[0] = d[7:0];  bp[0] = 0;
      ba[1] = a1; bd[1] = d[15:8]; bp[1] = split ? 1 : 0;
      for (int p = 0; p < 2; p++) begin
         e_adr[p] = '0;
         e_sel[p] = '0;
         e_dat[p] = '0;
      end
      for (int i = 0; i < nb; i++) begin
         e_adr[bp[i]]          = ba[i][19:1];
         e_sel[bp[i]][ba[i][0]] = 1'b1;
         if (ba[i][0]) e_dat[bp[i]][15:8] = bd[i];
         else          e_dat[bp[i]][7:0]  = bd[i];
      end
      if (!w_n) begin
         for (int i = 0; i < nb; i++) mmem[int'(ba[i])] = bd[i];
      end else begin
         memout_exp = b ? {8'h00, m_get(a)} : {m_get(a1), m_get(a)};
      end
      waits[0] = w1;
      waits[1] = w2;
      exp_lat  = split ? 4 + w1 + w2 : 2 + w1;
      exp_stbs = split ? 2 + w1 + w2 : 1 + w1;

      req = 1'b1; addr = a; wr_data = d; we = w_n; byteop = b;
      @(posedge clk); #1;
      if (!hold) begin
         req     = 1'b0;
         addr    = 20'($urandom);
         wr_data = 16'($urandom);
         we      = 1'($urandom);
         byteop  = 1'($urandom);
      end

      ph = 0; inph = 0; stbs = 0; done = 1'b0; k = 1;
      while (k <= 60 && !done) begin
         wb_ack_i = 1'b0;
         if (wb_stb_o) begin
            stbs++;
            if (ph >= nph) begin
               check($sformatf("extra_strobe@%05h", a), ph, nph - 1);
            end else begin
               if (inph == 0) begin
                  check($sformatf("cyc@%05h", a), wb_cyc_o, 1);
                  check($sformatf("adr%0d@%05h", ph, a), wb_adr_o, e_adr[ph]);
                  check($sformatf("sel%0d@%05h", ph, a), wb_sel_o, e_sel[ph]);
                  check($sformatf("we_o%0d@%05h", ph, a), wb_we_o, !w_n);
                  if (!w_n) check($sformatf("dat%0d@%05h", ph, a), wb_dat_o, e_dat[ph]);
               end
               if (inph == waits[ph]) begin
                  wb_dat_i = {s_get({wb_adr_o, 1'b1}), s_get({wb_adr_o, 1'b0})};
                  wb_ack_i = 1'b1;
                  if (wb_we_o) begin
                     if (wb_sel_o[0]) smem[int'({wb_adr_o, 1'b0})] = wb_dat_o[7:0];
                     if (wb_sel_o[1]) smem[int'({wb_adr_o, 1'b1})] = wb_dat_o[15:8];
                  end
                  ph++;
                  inph = 0;
               end else begin
                  inph++;
               end
            end
         end else if (ready) begin
            check($sformatf("memout@%05h", a), memout, memout_exp);
            check($sformatf("latency@%05h", a), k, exp_lat);
            check($sformatf("strobe_cycles@%05h", a), stbs, exp_stbs);
`ifdef MEMCTL_TIMEOUT_EN
            check($sformatf("err@%05h", a), err, err_exp);
`endif
            done = 1'b1;
         end
         if (!done) begin
            @(posedge clk); #1;
            k++;
         end
      end
      wb_ack_i = 1'b0;
      if (!done) check($sformatf("ready_seen@%05h", a), 0, 1);
      @(posedge clk); #1;
      check($sformatf("ready_pulse@%05h", a), ready, 0);
      check($sformatf("idle_stb@%05h", a), wb_stb_o, 0);
   endtask

   // Reset while the slave is still withholding ack on the first bus cycle.
   task automatic boot_mid(input logic [19:0] a);
      req = 1'b1; addr = a; wr_data = 16'h0000; we = 1'b1; byteop = 1'b0;
      @(posedge clk); #1;
      req = 1'b0;
      check("abort_stb_before", wb_stb_o, 1);
      @(posedge clk); #1;
      boot = 1'b1;
      @(posedge clk); #1;
      boot = 1'b0;
      check("abort_stb", wb_stb_o, 0);
      check("abort_cyc", wb_cyc_o, 0);
      check("abort_ready", ready, 0);
      check("abort_memout", memout, 16'h0000);
      memout_exp = 16'h0000;
`ifdef MEMCTL_TIMEOUT_EN
      err_exp = 1'b0;
`endif
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("abort_quiet_ready", ready, 0);
         check("abort_quiet_stb", wb_stb_o, 0);
      end
   endtask

`ifdef MEMCTL_TIMEOUT_EN
   task automatic timeout_run(input logic [19:0] a);
      int k;
      req = 1'b1; addr = a; wr_data = 16'h0000; we = 1'b1; byteop = 1'b0;
      @(posedge clk); #1;
      req = 1'b0;
      k = 1;
      while (k <= 40 && !ready) begin
         @(posedge clk); #1;
         k++;
      end
      check("to_latency", k, TO_LIM + 2);
      check("to_memout", memout, 16'hFFFF);
      check("to_err", err, 1);
      memout_exp = 16'hFFFF;
      err_exp    = 1'b1;
      @(posedge clk); #1;
      check("to_ready_pulse", ready, 0);
   endtask
`endif

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "bench time limit");
   end

   initial begin
      boot = 1'b1; req = 1'b0; addr = '0; wr_data = '0; we = 1'b1; byteop = 1'b0;
      wb_dat_i = '0; wb_ack_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      boot = 1'b0;
      check("rst_ready", ready, 0);
      check("rst_memout", memout, 16'h0000);
      check("rst_stb", wb_stb_o, 0);
      check("rst_cyc", wb_cyc_o, 0);
      check("rst_we_o", wb_we_o, 0);
      check("rst_sel", wb_sel_o, 2'b00);
      check("rst_adr", wb_adr_o, 19'h0);
      check("rst_dat", wb_dat_o, 16'h0000);
`ifdef MEMCTL_TIMEOUT_EN
      check("rst_err", err, 0);
`endif

      preload(20'h01234, 8'hEF);
      preload(20'h01235, 8'hBE);
      preload(20'h00100, 8'hAB);
      preload(20'h00101, 8'h12);
      preload(20'h00102, 8'h34);
      preload(20'h00103, 8'hCD);

      run_txn(20'h01234, 16'h0000, 1'b1, 1'b0, 0, 0, 1'b0);  // aligned word read
      run_txn(20'h00101, 16'h0000, 1'b1, 1'b0, 0, 0, 1'b0);  // unaligned word read
      run_txn(20'h00101, 16'h005A, 1'b0, 1'b1, 0, 0, 1'b0);  // byte write, odd lane
      run_txn(20'h00101, 16'h0000, 1'b1, 1'b1, 1, 0, 1'b0);  // byte read back
      run_txn(20'hFFFFF, 16'hA1B2, 1'b0, 1'b0, 0, 0, 1'b0);  // split write across wrap
      run_txn(20'hFFFFF, 16'h0000, 1'b1, 1'b0, 2, 1, 1'b0);  // split read across wrap
      run_txn(20'h00000, 16'h0000, 1'b1, 1'b1, 0, 0, 1'b0);  // even byte read

      // req held through DONE: must only be taken again from IDLE.
      run_txn(20'h01234, 16'h0000, 1'b1, 1'b0, 1, 0, 1'b1);
      run_txn(20'h01234, 16'h0000, 1'b1, 1'b0, 0, 0, 1'b0);

      boot_mid(20'h00400);

`ifdef MEMCTL_TIMEOUT_EN
      timeout_run(20'h00200);
      run_txn(20'h01234, 16'h0000, 1'b1, 1'b0, 0, 0, 1'b0);  // err stays set
      boot = 1'b1;
      @(posedge clk); #1;
      boot = 1'b0;
      memout_exp = 16'h0000;
      err_exp    = 1'b0;
      check("err_cleared", err, 0);
`endif

      for (int i = 0; i < 40; i++) begin
         logic [19:0] ra;
         logic [15:0] rd;
         ra = 20'($urandom);
         if ($urandom_range(0, 3) == 0) ra = 20'h00100 + 20'($urandom_range(0, 7));
         if ($urandom_range(0, 7) == 0) ra = 20'hFFFFF - 20'($urandom_range(0, 1));
         rd = 16'($urandom);
         run_txn(ra, rd, 1'($urandom), 1'($urandom),
                 int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
